// File: rtl/gps_iq_packer_if.sv
// rtl/gps_iq_packer_if.sv - byte stream interface for the packed IQ output
// Purpose: carries packed IQ bytes from gps_iq_packer to the host/file-dump sink.
// Signals:
//   out_data   8  packed byte {q1,i1,q0,i0}
//   out_valid  1  out_data holds a byte
//   out_ready  1  sink accepts the byte when out_valid && out_ready
// Modports: master = byte producer, slave = byte consumer.
interface gps_iq_packer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/gps_iq_packer.sv
// rtl/gps_iq_packer.sv - packs 2-bit L1 I/Q samples into bytes and buffers them in a FIFO
// Purpose: samples I/Q on each rising adc_clk edge (adc_clk treated as data),
//   packs two samples per byte as {q1,i1,q0,i0} and queues bytes in a show-ahead FIFO.
// Ports:
//   clk, rst        system clock; asynchronous active-low reset
//   pack_en         1 = capture and pack; 0 = idle, partial byte discarded
//   adc_clk         front-end sample clock, synchronised and edge-detected
//   i_sample        2-bit I sample
//   q_sample        2-bit Q sample
//   iq_out          byte stream (out_data/out_valid/out_ready)
//   fifo_level      bytes currently held
//   overflow        sticky flag, set when a completed byte is dropped
//   clr_overflow    pulse clearing overflow and drop_count
//   byte_count      bytes written into the FIFO (wraps)
//   drop_count      bytes dropped on a full FIFO (saturates)
module gps_iq_packer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pack_en,
  input  logic                 adc_clk,
  input  logic [1:0]           i_sample,
  input  logic [1:0]           q_sample,
  gps_iq_packer_if.master      iq_out,
  output logic [LW-1:0]        fifo_level,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic [CNT_W-1:0]     byte_count,
  output logic [CNT_W-1:0]     drop_count
);

  // {adc_clk, q, i} travel together so the sample stays aligned with its edge.
  logic [4:0]    sync_q [SYNC_STAGES];
  logic          adc_prev;
  logic          phase;
  logic [3:0]    nib0;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          out_valid_q;

  logic [4:0]    tap;
  logic          capture;
  logic          push;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;
  logic [7:0]    wr_byte;
  logic [LW-1:0] level_after_pop;

  assign tap             = sync_q[SYNC_STAGES-1];
  assign capture         = tap[4] & ~adc_prev;
  assign push            = capture & pack_en & phase;
  assign pop             = out_valid_q & iq_out.out_ready;
  assign full            = (fifo_level == LW'(FIFO_DEPTH));
  // A full FIFO still takes the byte when a pop frees a slot on the same edge.
  assign accept          = push & (~full | pop);
  assign drop            = push & full & ~pop;
  assign wr_byte         = {tap[3:0], nib0};
  assign level_after_pop = fifo_level - LW'(pop);

  // Show-ahead read; data is forced to zero whenever nothing is presented.
  assign iq_out.out_valid = out_valid_q;
  assign iq_out.out_data  = out_valid_q ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      adc_prev    <= 1'b0;
      phase       <= 1'b0;
      nib0        <= 4'h0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      out_valid_q <= 1'b0;
      overflow    <= 1'b0;
      byte_count  <= '0;
      drop_count  <= '0;
    end else begin
      sync_q[0] <= {adc_clk, q_sample, i_sample};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      adc_prev <= tap[4];

      if (!pack_en) begin
        phase <= 1'b0;
      end else if (capture) begin
        if (!phase) nib0 <= tap[3:0];
        phase <= ~phase;
      end

      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        byte_count <= byte_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_after_pop + LW'(accept);

      // Entries pushed this cycle are not counted, so valid rises one cycle
      // after a write into an empty FIFO; remaining entries show without a bubble.
      out_valid_q <= (level_after_pop != '0);

      // A drop on the same cycle as a clear wins: the count restarts at one.
      if (drop) begin
        overflow <= 1'b1;
        if (clr_overflow)     drop_count <= CNT_W'(1);
        else if (!(&drop_count)) drop_count <= drop_count + 1'b1;
      end else if (clr_overflow) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_byte;
  end

endmodule

// File: tb/tb_gps_iq_packer.sv
// tb/tb_gps_iq_packer.sv - directed self-checking bench for gps_iq_packer
module tb_gps_iq_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pack_en = 1'b0;
  logic        adc_clk = 1'b0;
  logic        clr_overflow = 1'b0;
  logic [1:0]  i_sample = 2'b00;
  logic [1:0]  q_sample = 2'b00;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [31:0] byte_count;
  logic [31:0] drop_count;

  int total = 0;
  int bad   = 0;
  int rk;
  logic [7:0] popped [$];
  logic [3:0] na;
  logic [3:0] nb;

  gps_iq_packer_if bus ();

  gps_iq_packer #(.FIFO_DEPTH(16), .SYNC_STAGES(2), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pack_en      (pack_en),
    .adc_clk      (adc_clk),
    .i_sample     (i_sample),
    .q_sample     (q_sample),
    .iq_out       (bus),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .byte_count   (byte_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst && bus.out_valid && bus.out_ready) popped.push_back(bus.out_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. adc_clk high for 3 cycles, low for 3. rise_k reports the
  // cycle (1..6 after the rise) on which out_valid was first seen rising, else 0.
  task automatic do_edge(input logic [1:0] iv, input logic [1:0] qv,
                         input bit rdy_pulse, output int rise_k);
    logic pv;
    rise_k   = 0;
    adc_clk  = 1'b1;
    i_sample = iv;
    q_sample = qv;
    pv       = bus.out_valid;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid && !pv && rise_k == 0) rise_k = k;
      pv = bus.out_valid;
      if (k == 3) adc_clk = 1'b0;
      if (rdy_pulse && k == 2) bus.out_ready = 1'b1;
      if (rdy_pulse && k == 3) bus.out_ready = 1'b0;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(1);
    popped.delete();
  endtask

  initial begin
    bus.out_ready = 1'b0;
    #1 rst = 1'b0;
    wait_cycles(3);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_level", 32'(fifo_level),    32'd0);
    chk("rst_ovf",   32'(overflow),      32'd0);
    chk("rst_bytes", byte_count,         32'd0);
    chk("rst_drops", drop_count,         32'd0);
    rst = 1'b1;
    wait_cycles(1);

    // Test 1: basic packing and first-byte latency
    pack_en = 1'b1;
    bus.out_ready = 1'b1;
    do_edge(2'b01, 2'b10, 1'b0, rk);
    do_edge(2'b11, 2'b00, 1'b0, rk);
    chk("t1_latency", 32'(rk), 32'd4);
    do_edge(2'b00, 2'b01, 1'b0, rk);
    do_edge(2'b10, 2'b11, 1'b0, rk);
    wait_cycles(4);
    chk("t1_npop",  32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      chk("t1_b0", 32'(popped[0]), 32'h39);
      chk("t1_b1", 32'(popped[1]), 32'hE4);
    end
    chk("t1_bytes", byte_count, 32'd2);
    chk("t1_level", 32'(fifo_level), 32'd0);

    // Test 2: fill under backpressure, one drop, then drain in order
    pulse_reset();
    bus.out_ready = 1'b0;
    for (int n = 0; n < 32; n++) begin
      na = 4'(n);
      do_edge(na[1:0], na[3:2], 1'b0, rk);
    end
    chk("t2_full_level", 32'(fifo_level), 32'd16);
    chk("t2_full_ovf",   32'(overflow),   32'd0);
    do_edge(2'b00, 2'b00, 1'b0, rk);
    do_edge(2'b01, 2'b00, 1'b0, rk);
    chk("t2_level", 32'(fifo_level), 32'd16);
    chk("t2_ovf",   32'(overflow),   32'd1);
    chk("t2_drops", drop_count,      32'd1);
    chk("t2_bytes", byte_count,      32'd16);
    chk("t2_hold_data", 32'(bus.out_data), 32'h10);
    bus.out_ready = 1'b1;
    wait_cycles(20);
    bus.out_ready = 1'b0;
    chk("t2_npop", 32'(popped.size()), 32'd16);
    for (int b = 0; b < 16 && b < popped.size(); b++) begin
      na = 4'(2 * b);
      nb = 4'(2 * b + 1);
      chk($sformatf("t2_b%0d", b), 32'(popped[b]), 32'({nb, na}));
    end
    chk("t2_drained", 32'(fifo_level), 32'd0);

    // Test 6: clearing overflow keeps byte_count
    clr_overflow = 1'b1;
    wait_cycles(1);
    clr_overflow = 1'b0;
    chk("t6_ovf",   32'(overflow), 32'd0);
    chk("t6_drops", drop_count,    32'd0);
    chk("t6_bytes", byte_count,    32'd16);

    // Test 3: push into a full FIFO on the same cycle as a pop
    popped.delete();
    for (int n = 0; n < 32; n++) begin
      na = 4'(n);
      do_edge(na[1:0], na[3:2], 1'b0, rk);
    end
    chk("t3_full", 32'(fifo_level), 32'd16);
    do_edge(2'b11, 2'b11, 1'b0, rk);
    do_edge(2'b00, 2'b10, 1'b1, rk);
    chk("t3_level", 32'(fifo_level), 32'd16);
    chk("t3_ovf",   32'(overflow),   32'd0);
    chk("t3_drops", drop_count,      32'd0);
    chk("t3_bytes", byte_count,      32'd33);
    bus.out_ready = 1'b1;
    wait_cycles(20);
    chk("t3_npop", 32'(popped.size()), 32'd17);
    if (popped.size() == 17) begin
      chk("t3_first", 32'(popped[0]),  32'h10);
      chk("t3_last",  32'(popped[16]), 32'h8F);
    end

    // Test 4: pack_en low discards the partial byte and ignores edges
    pulse_reset();
    bus.out_ready = 1'b1;
    pack_en = 1'b1;
    do_edge(2'b01, 2'b00, 1'b0, rk);
    do_edge(2'b10, 2'b01, 1'b0, rk);
    do_edge(2'b11, 2'b11, 1'b0, rk);
    pack_en = 1'b0;
    do_edge(2'b01, 2'b01, 1'b0, rk);
    do_edge(2'b01, 2'b01, 1'b0, rk);
    pack_en = 1'b1;
    do_edge(2'b00, 2'b10, 1'b0, rk);
    do_edge(2'b01, 2'b11, 1'b0, rk);
    wait_cycles(4);
    chk("t4_npop", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      chk("t4_b0", 32'(popped[0]), 32'h61);
      chk("t4_b1", 32'(popped[1]), 32'hD8);
    end

    // Test 5: asynchronous reset mid-byte with bytes queued
    pulse_reset();
    bus.out_ready = 1'b0;
    for (int n = 0; n < 11; n++) begin
      na = 4'(n + 3);
      do_edge(na[1:0], na[3:2], 1'b0, rk);
    end
    chk("t5_pre_level", 32'(fifo_level), 32'd5);
    rst = 1'b0;
    #2;
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_data",  32'(bus.out_data),  32'd0);
    chk("t5_level", 32'(fifo_level),    32'd0);
    chk("t5_bytes", byte_count,         32'd0);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(1);
    popped.delete();
    bus.out_ready = 1'b1;
    do_edge(2'b10, 2'b00, 1'b0, rk);
    do_edge(2'b01, 2'b11, 1'b0, rk);
    wait_cycles(4);
    chk("t5_npop", 32'(popped.size()), 32'd1);
    if (popped.size() == 1) chk("t5_b0", 32'(popped[0]), 32'hD2);
    chk("t5_count", byte_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
